// File: rtl/sram_rw_arbiter.sv
// sram_rw_arbiter: shares the 1RW port (port 0) of the SRAM macro between two
// requesters. Grants are combinational and round-robin. Reads are tracked
// through the macro latency, and each read response goes back to the requester
// that issued it.
// Optional build macro: ARB_FIXED_PRIO_EN gives requester 0 fixed priority
// instead of round-robin.
module sram_rw_arbiter #(
    parameter int unsigned NUM_WMASKS   = 4,
    parameter int unsigned DATA_WIDTH   = 32,
    parameter int unsigned ADDR_WIDTH   = 10,
    parameter int unsigned SRAM_LATENCY = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  r0_valid,
    output logic                  r0_ready,
    input  logic                  r0_we,
    input  logic [NUM_WMASKS-1:0] r0_wmask,
    input  logic [ADDR_WIDTH-1:0] r0_addr,
    input  logic [DATA_WIDTH-1:0] r0_wdata,
    output logic                  r0_rsp_valid,
    output logic [DATA_WIDTH-1:0] r0_rsp_rdata,
    input  logic                  r1_valid,
    output logic                  r1_ready,
    input  logic                  r1_we,
    input  logic [NUM_WMASKS-1:0] r1_wmask,
    input  logic [ADDR_WIDTH-1:0] r1_addr,
    input  logic [DATA_WIDTH-1:0] r1_wdata,
    output logic                  r1_rsp_valid,
    output logic [DATA_WIDTH-1:0] r1_rsp_rdata,
    output logic                  sram_csb0,
    output logic                  sram_web0,
    output logic [NUM_WMASKS-1:0] sram_wmask0,
    output logic [ADDR_WIDTH-1:0] sram_addr0,
    output logic [DATA_WIDTH-1:0] sram_din0,
    input  logic [DATA_WIDTH-1:0] sram_dout0,
    output logic                  prio_ptr
);

    localparam int unsigned LAST = SRAM_LATENCY - 1;

    logic                    prio_q;
    logic                    gnt0_c;
    logic                    gnt1_c;
    logic                    rd_accept_c;
    logic [SRAM_LATENCY-1:0] pipe_v;
    logic [SRAM_LATENCY-1:0] pipe_id;
    logic                    rsp_v_c;

    // Grant selection; reset suppresses all grants
    always_comb begin
        gnt0_c = 1'b0;
        gnt1_c = 1'b0;
        if (rst_n) begin
`ifdef ARB_FIXED_PRIO_EN
            gnt0_c = r0_valid;
            gnt1_c = r1_valid & ~r0_valid;
`else
            if (r0_valid && r1_valid) begin
                gnt0_c = ~prio_q;
                gnt1_c = prio_q;
            end else begin
                gnt0_c = r0_valid;
                gnt1_c = r1_valid;
            end
`endif
        end
    end

    assign r0_ready = gnt0_c;
    assign r1_ready = gnt1_c;
    assign prio_ptr = prio_q;

    // Drive the macro port from the granted requester, otherwise idle with zeros
    always_comb begin
        sram_csb0   = 1'b1;
        sram_web0   = 1'b1;
        sram_wmask0 = '0;
        sram_addr0  = '0;
        sram_din0   = '0;
        rd_accept_c = 1'b0;
        if (gnt0_c) begin
            sram_csb0   = 1'b0;
            sram_web0   = ~r0_we;
            sram_wmask0 = r0_we ? r0_wmask : '0;
            sram_addr0  = r0_addr;
            sram_din0   = r0_wdata;
            rd_accept_c = ~r0_we;
        end else if (gnt1_c) begin
            sram_csb0   = 1'b0;
            sram_web0   = ~r1_we;
            sram_wmask0 = r1_we ? r1_wmask : '0;
            sram_addr0  = r1_addr;
            sram_din0   = r1_wdata;
            rd_accept_c = ~r1_we;
        end
    end

    // Round-robin pointer: after a grant the other requester gets priority
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            prio_q <= 1'b0;
        end else begin
`ifdef ARB_FIXED_PRIO_EN
            prio_q <= 1'b0;
`else
            if (gnt0_c) begin
                prio_q <= 1'b1;
            end else if (gnt1_c) begin
                prio_q <= 1'b0;
            end
`endif
        end
    end

    // Read tracking shift pipeline: stage 0 takes the accepted read and the
    // last stage lines up with valid dout0
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pipe_v  <= '0;
            pipe_id <= '0;
        end else begin
            pipe_v  <= SRAM_LATENCY'({pipe_v, rd_accept_c});
            pipe_id <= SRAM_LATENCY'({pipe_id, gnt1_c});
        end
    end

    // Route the response to its issuer; rst_n also masks a response that is
    // still in flight while reset is being applied
    assign rsp_v_c      = rst_n & pipe_v[LAST];
    assign r0_rsp_valid = rsp_v_c & ~pipe_id[LAST];
    assign r1_rsp_valid = rsp_v_c & pipe_id[LAST];
    assign r0_rsp_rdata = r0_rsp_valid ? sram_dout0 : '0;
    assign r1_rsp_rdata = r1_rsp_valid ? sram_dout0 : '0;

endmodule

// File: tb/tb_sram_rw_arbiter.sv
// Testbench for sram_rw_arbiter: a behavioural SRAM, a reference model of
// grants and memory contents, and a response scoreboard.
module tb_sram_rw_arbiter;

    localparam int unsigned NW  = 4;
    localparam int unsigned DW  = 32;
    localparam int unsigned AW  = 10;
    localparam int unsigned LAT = 1;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          r0_valid, r0_ready, r0_we, r0_rsp_valid;
    logic [NW-1:0] r0_wmask;
    logic [AW-1:0] r0_addr;
    logic [DW-1:0] r0_wdata, r0_rsp_rdata;
    logic          r1_valid, r1_ready, r1_we, r1_rsp_valid;
    logic [NW-1:0] r1_wmask;
    logic [AW-1:0] r1_addr;
    logic [DW-1:0] r1_wdata, r1_rsp_rdata;
    logic          sram_csb0, sram_web0, prio_ptr;
    logic [NW-1:0] sram_wmask0;
    logic [AW-1:0] sram_addr0;
    logic [DW-1:0] sram_din0, sram_dout0;

    sram_rw_arbiter #(
        .NUM_WMASKS(NW), .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .SRAM_LATENCY(LAT)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .r0_valid(r0_valid), .r0_ready(r0_ready), .r0_we(r0_we), .r0_wmask(r0_wmask),
        .r0_addr(r0_addr), .r0_wdata(r0_wdata), .r0_rsp_valid(r0_rsp_valid),
        .r0_rsp_rdata(r0_rsp_rdata),
        .r1_valid(r1_valid), .r1_ready(r1_ready), .r1_we(r1_we), .r1_wmask(r1_wmask),
        .r1_addr(r1_addr), .r1_wdata(r1_wdata), .r1_rsp_valid(r1_rsp_valid),
        .r1_rsp_rdata(r1_rsp_rdata),
        .sram_csb0(sram_csb0), .sram_web0(sram_web0), .sram_wmask0(sram_wmask0),
        .sram_addr0(sram_addr0), .sram_din0(sram_din0), .sram_dout0(sram_dout0),
        .prio_ptr(prio_ptr)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural SRAM macro port 0 with LAT-cycle read latency
    logic [DW-1:0] smem [1024];
    logic [DW-1:0] rd_pipe [LAT];
    always @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < 1024; i++) smem[i] <= '0;
        end else if (!sram_csb0) begin
            if (!sram_web0) begin
                for (int b = 0; b < int'(NW); b++)
                    if (sram_wmask0[b]) smem[sram_addr0][8*b +: 8] <= sram_din0[8*b +: 8];
            end else begin
                rd_pipe[0] <= smem[sram_addr0];
            end
        end
        for (int i = 1; i < int'(LAT); i++) rd_pipe[i] <= rd_pipe[i-1];
    end
    assign sram_dout0 = rd_pipe[LAT-1];

    // Reference model state and scoreboard
    typedef struct {
        int          id;
        logic [31:0] data;
        int          due;
    } rsp_t;
    rsp_t        q[$];
    logic [31:0] ref_mem [1024];
    int          prio_m = 0;
    int          checks = 0;
    int          errors = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %h expected %h", nm, cyc, act, exp);
        end
    endtask

    // Drive one cycle, check the combinational grant/port outputs, update model
    task automatic step(input logic rst,
                        input logic v0, input logic we0, input logic [3:0] m0,
                        input logic [9:0] a0, input logic [31:0] d0,
                        input logic v1, input logic we1, input logic [3:0] m1,
                        input logic [9:0] a1, input logic [31:0] d1);
        int          g;
        logic        gw;
        logic [3:0]  gm;
        logic [9:0]  ga;
        logic [31:0] gd;
        rst_n = rst;
        r0_valid = v0; r0_we = we0; r0_wmask = m0; r0_addr = a0; r0_wdata = d0;
        r1_valid = v1; r1_we = we1; r1_wmask = m1; r1_addr = a1; r1_wdata = d1;
        @(negedge clk);
        g = -1;
        if (rst) begin
            if (v0 && v1) begin
`ifdef ARB_FIXED_PRIO_EN
                g = 0;
`else
                g = prio_m;
`endif
            end else if (v0) g = 0;
            else if (v1) g = 1;
        end
        gw = (g == 1) ? we1 : we0;
        gm = (g == 1) ? m1 : m0;
        ga = (g == 1) ? a1 : a0;
        gd = (g == 1) ? d1 : d0;
        chk("r0_ready", 32'(r0_ready), 32'(g == 0));
        chk("r1_ready", 32'(r1_ready), 32'(g == 1));
        chk("prio_ptr", 32'(prio_ptr), prio_m);
        chk("sram_csb0", 32'(sram_csb0), 32'(g < 0));
        chk("sram_web0", 32'(sram_web0), (g < 0) ? 32'd1 : 32'(!gw));
        chk("sram_wmask0", 32'(sram_wmask0), (g >= 0 && gw) ? 32'(gm) : 32'd0);
        chk("sram_addr0", 32'(sram_addr0), (g >= 0) ? 32'(ga) : 32'd0);
        chk("sram_din0", sram_din0, (g >= 0) ? gd : 32'd0);
        if (!rst) begin
            prio_m = 0;
            for (int i = 0; i < 1024; i++) ref_mem[i] = '0;
        end else if (g >= 0) begin
`ifndef ARB_FIXED_PRIO_EN
            prio_m = (g == 0) ? 1 : 0;
`endif
            if (gw) begin
                for (int b = 0; b < 4; b++)
                    if (gm[b]) ref_mem[ga][8*b +: 8] = gd[8*b +: 8];
            end else begin
                q.push_back('{g, ref_mem[ga], cyc + int'(LAT)});
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input logic rst);
        step(rst, 1'b0, 1'b0, 4'h0, 10'h0, 32'h0, 1'b0, 1'b0, 4'h0, 10'h0, 32'h0);
    endtask

    // Response monitor: pops the scoreboard whenever a response appears
    always @(negedge clk) begin
        if (!rst_n) begin
            chk("rsp_valid_in_reset", 32'({r0_rsp_valid, r1_rsp_valid}), 32'd0);
            q.delete();
        end else begin
            if (!r0_rsp_valid) chk("r0_rdata_idle", r0_rsp_rdata, 32'd0);
            if (!r1_rsp_valid) chk("r1_rdata_idle", r1_rsp_rdata, 32'd0);
            if (r0_rsp_valid && r1_rsp_valid) begin
                chk("rsp_both_valid", 32'd1, 32'd0);
            end else if (r0_rsp_valid || r1_rsp_valid) begin
                if (q.size() == 0) begin
                    chk("rsp_unexpected", 32'd1, 32'd0);
                end else begin
                    rsp_t e;
                    e = q.pop_front();
                    chk("rsp_id", 32'(r1_rsp_valid), 32'(e.id));
                    chk("rsp_data", r1_rsp_valid ? r1_rsp_rdata : r0_rsp_rdata, e.data);
                    chk("rsp_cycle", cyc, e.due);
                end
            end else if (q.size() > 0 && q[0].due <= cyc) begin
                chk("rsp_missing", 32'd0, 32'd1);
                void'(q.pop_front());
            end
        end
    end

    initial begin
        rst_n = 1'b0;
        r0_valid = 1'b1; r0_we = 1'b0; r0_wmask = '0; r0_addr = '0; r0_wdata = '0;
        r1_valid = 1'b1; r1_we = 1'b0; r1_wmask = '0; r1_addr = '0; r1_wdata = '0;
        @(posedge clk);
        #1;
        // Reset with both requesters valid
        step(1'b0, 1'b1, 1'b0, 4'h0, 10'h0, 32'h0, 1'b1, 1'b0, 4'h0, 10'h0, 32'h0);
        step(1'b0, 1'b1, 1'b0, 4'h0, 10'h0, 32'h0, 1'b1, 1'b0, 4'h0, 10'h0, 32'h0);
        // Single requester write then read
        step(1'b1, 1'b1, 1'b1, 4'hF, 10'h005, 32'hDEADBEEF, 1'b0, 1'b0, 4'h0, 10'h0, 32'h0);
        step(1'b1, 1'b1, 1'b0, 4'h0, 10'h005, 32'h0, 1'b0, 1'b0, 4'h0, 10'h0, 32'h0);
        idle(1'b1);
        // Byte-masked write at the top address
        step(1'b1, 1'b1, 1'b1, 4'hF, 10'h3FF, 32'h11223344, 1'b0, 1'b0, 4'h0, 10'h0, 32'h0);
        step(1'b1, 1'b1, 1'b1, 4'h2, 10'h3FF, 32'hAABBCCDD, 1'b0, 1'b0, 4'h0, 10'h0, 32'h0);
        step(1'b1, 1'b0, 1'b0, 4'h0, 10'h0, 32'h0, 1'b1, 1'b0, 4'h0, 10'h3FF, 32'h0);
        idle(1'b1);
        // Contention from reset: both read continuously for 4 cycles
        step(1'b1, 1'b1, 1'b1, 4'hF, 10'h00A, 32'hCAFEF00D, 1'b0, 1'b0, 4'h0, 10'h0, 32'h0);
        idle(1'b0);
        step(1'b1, 1'b1, 1'b1, 4'hF, 10'h00A, 32'hCAFEF00D, 1'b0, 1'b0, 4'h0, 10'h0, 32'h0);
        step(1'b1, 1'b0, 1'b1, 4'hF, 10'h00B, 32'h0BADF00D, 1'b0, 1'b0, 4'h0, 10'h0, 32'h0);
        idle(1'b0);
        idle(1'b1);
        for (int i = 0; i < 4; i++)
            step(1'b1, 1'b1, 1'b0, 4'h0, 10'h001, 32'h0, 1'b1, 1'b0, 4'h0, 10'h002, 32'h0);
        idle(1'b1);
        // Reset right after a read is accepted
        step(1'b1, 1'b1, 1'b0, 4'h0, 10'h005, 32'h0, 1'b0, 1'b0, 4'h0, 10'h0, 32'h0);
        idle(1'b0);
        idle(1'b1);
        idle(1'b1);
        // Randomised traffic over a small address window
        for (int i = 0; i < 600; i++) begin
            step(($urandom_range(0, 59) != 0),
                 1'($urandom), 1'($urandom), 4'($urandom), 10'($urandom_range(0, 15)), $urandom,
                 1'($urandom), 1'($urandom), 4'($urandom), 10'($urandom_range(0, 15)), $urandom);
        end
        for (int i = 0; i < int'(LAT) + 2; i++) idle(1'b1);
        chk("scoreboard_drained", q.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
